// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker pipeline.
// Transaction bundle, walk/flush encodings, memory-stage states.
package mpt_pkg;

  typedef logic [63:0] mpt_entry_t;

  typedef enum logic [1:0] {
    MPT_WALKING_SKIP = 2'd0,
    MPT_WALKING_DO   = 2'd1,
    MPT_WALKING_FWD  = 2'd2
  } mptw_walking_e;

  typedef struct packed {
    logic          valid;
    mptw_walking_e walking;
    logic          err;
    logic [31:0]   mpte_ptr;
    mpt_entry_t    mpte;
  } mptw_transaction_t;

  typedef enum logic {
    MPT_FLUSH_NONE = 1'b0,
    MPT_FLUSH_ALL  = 1'b1
  } mptw_flush_ctrl_e;

  typedef enum logic [1:0] {
    MPT_FLUSH_IDLE    = 2'd0,
    MPT_FLUSH_PENDING = 2'd1,
    MPT_FLUSH_DONE    = 2'd2
  } mptw_flush_status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } mptw_mem_state_e;

  localparam int unsigned MPTW_TXN_W =
    $bits(mptw_transaction_t);

  function automatic logic needs_fetch(
    input mptw_transaction_t t
  );
    return t.valid &&
      (t.walking == MPT_WALKING_DO);
  endfunction

endpackage

// File: rtl/mpte_fetch_stage.sv
// MPT walker memory stage: one MPTE read per DO
// transaction, update to forwarding buffer, then pass on.
module mpte_fetch_stage
  import mpt_pkg::*;
#(
  parameter int unsigned TRANSACTION_DATA_WIDTH = MPTW_TXN_W,
  parameter int unsigned MEM_ADDR_WIDTH = 64,
  parameter int unsigned MEM_DATA_WIDTH = 64
) (
  input  logic clk_i,
  input  logic rst_ni,

  input  logic fwd_slave_stage_valid,
  output logic fwd_slave_stage_ready,
  input  logic [TRANSACTION_DATA_WIDTH-1:0]
    fwd_slave_stage_data,

  output logic update_master_stage_valid,
  input  logic update_master_stage_ready,
  output logic [TRANSACTION_DATA_WIDTH-1:0]
    update_master_stage_data,

  output logic next_master_stage_valid,
  input  logic next_master_stage_ready,
  output logic [TRANSACTION_DATA_WIDTH-1:0]
    next_master_stage_data,

  output logic mem_req_o,
  input  logic mem_gnt_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic mem_rvalid_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic mem_err_i,

  input  logic [$bits(mptw_flush_ctrl_e)-1:0]
    stage_ctrl_flush,
  output logic [$bits(mptw_flush_status_e)-1:0]
    stage_status_flush
);

  mptw_mem_state_e    state_q;
  mptw_transaction_t  txn_q;
  mptw_transaction_t  txn_in;
  mptw_flush_status_e status_q;
  logic               drop_q;
  logic               upd_q;
  logic               flush_req;
  logic               accept;
  logic               unused_upd_ready;

  // The forwarding buffer always takes updates.
  assign unused_upd_ready = update_master_stage_ready;

  assign txn_in    = mptw_transaction_t'(fwd_slave_stage_data);
  assign flush_req = (stage_ctrl_flush != MPT_FLUSH_NONE);

  assign fwd_slave_stage_ready =
    (state_q == IDLE) && !flush_req;
  assign accept =
    fwd_slave_stage_valid && fwd_slave_stage_ready;

  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = (state_q == REQ) ?
    MEM_ADDR_WIDTH'(txn_q.mpte_ptr) : '0;

  assign next_master_stage_valid = (state_q == OUT);
  assign next_master_stage_data  =
    TRANSACTION_DATA_WIDTH'(txn_q);

  assign update_master_stage_valid = upd_q;
  assign update_master_stage_data  =
    TRANSACTION_DATA_WIDTH'(txn_q);

  assign stage_status_flush = status_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      txn_q    <= '0;
      drop_q   <= 1'b0;
      upd_q    <= 1'b0;
      status_q <= MPT_FLUSH_IDLE;
    end else begin
      upd_q    <= 1'b0;
      status_q <= MPT_FLUSH_IDLE;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            txn_q   <= txn_in;
            state_q <= needs_fetch(txn_in) ? REQ : OUT;
          end
        end
        REQ: begin
          // A granted request cannot be retracted; mark it.
          if (flush_req || drop_q) begin
            drop_q   <= 1'b1;
            status_q <= MPT_FLUSH_PENDING;
          end
          if (mem_gnt_i) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (flush_req || drop_q) begin
              drop_q   <= 1'b0;
              txn_q    <= '0;
              state_q  <= IDLE;
              status_q <= MPT_FLUSH_DONE;
            end else begin
              if (mem_err_i) txn_q.err <= 1'b1;
              else txn_q.mpte <= mpt_entry_t'(mem_rdata_i);
              upd_q   <= !mem_err_i;
              state_q <= OUT;
            end
          end else if (flush_req || drop_q) begin
            drop_q   <= 1'b1;
            status_q <= MPT_FLUSH_PENDING;
          end
        end
        OUT: begin
          if (flush_req) begin
            txn_q    <= '0;
            state_q  <= IDLE;
            status_q <= MPT_FLUSH_DONE;
          end else if (next_master_stage_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpte_fetch_stage.sv
// Directed bench for mpte_fetch_stage.
// Linear steps; inputs change and outputs sampled 1ns after posedge.
module tb_mpte_fetch_stage;
  import mpt_pkg::*;

  localparam int TW = MPTW_TXN_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          fwd_valid, fwd_ready;
  logic [TW-1:0] fwd_data;
  logic          upd_valid, upd_ready;
  logic [TW-1:0] upd_data;
  logic          nxt_valid, nxt_ready;
  logic [TW-1:0] nxt_data;
  logic          mem_req, mem_gnt;
  logic [63:0]   mem_addr;
  logic          mem_rvalid, mem_err;
  logic [63:0]   mem_rdata;
  logic [0:0]    flush;
  logic [1:0]    fstat;

  int compared   = 0;
  int mismatched = 0;

  mpte_fetch_stage dut (
    .clk_i                     (clk),
    .rst_ni                    (rst_n),
    .fwd_slave_stage_valid     (fwd_valid),
    .fwd_slave_stage_ready     (fwd_ready),
    .fwd_slave_stage_data      (fwd_data),
    .update_master_stage_valid (upd_valid),
    .update_master_stage_ready (upd_ready),
    .update_master_stage_data  (upd_data),
    .next_master_stage_valid   (nxt_valid),
    .next_master_stage_ready   (nxt_ready),
    .next_master_stage_data    (nxt_data),
    .mem_req_o                 (mem_req),
    .mem_gnt_i                 (mem_gnt),
    .mem_addr_o                (mem_addr),
    .mem_rvalid_i              (mem_rvalid),
    .mem_rdata_i               (mem_rdata),
    .mem_err_i                 (mem_err),
    .stage_ctrl_flush          (flush),
    .stage_status_flush        (fstat)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic mptw_transaction_t mk(
    input mptw_walking_e w,
    input logic [31:0] ptr,
    input logic [63:0] e
  );
    mptw_transaction_t t;
    t.valid    = 1'b1;
    t.walking  = w;
    t.err      = 1'b0;
    t.mpte_ptr = ptr;
    t.mpte     = e;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mptw_transaction_t ta, tb, ex;
    rst_n      = 1'b0;
    fwd_valid  = 1'b0;
    fwd_data   = '0;
    upd_ready  = 1'b1;
    nxt_ready  = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    flush      = MPT_FLUSH_NONE;

    // reset state
    tick(); tick();
    chk("rst_nvalid", 128'(nxt_valid), 128'(0));
    chk("rst_uvalid", 128'(upd_valid), 128'(0));
    chk("rst_req", 128'(mem_req), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_status", 128'(fstat), 128'(MPT_FLUSH_IDLE));
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 128'(fwd_ready), 128'(1));

    // SKIP bypass
    ta = mk(MPT_WALKING_SKIP, 32'h1000, 64'h55);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    tick();
    fwd_valid = 1'b0;
    chk("skip_nvalid", 128'(nxt_valid), 128'(1));
    chk("skip_data", 128'(nxt_data), 128'(ta));
    chk("skip_req", 128'(mem_req), 128'(0));
    chk("skip_uvalid", 128'(upd_valid), 128'(0));
    chk("skip_ready", 128'(fwd_ready), 128'(0));
    tick();
    chk("skip_done", 128'(nxt_valid), 128'(0));

    // DO with gnt delayed 3 cycles
    ta = mk(MPT_WALKING_DO, 32'h2040, 64'h0);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    tick();
    fwd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("do_req", 128'(mem_req), 128'(1));
      chk("do_addr", 128'(mem_addr), 128'(64'h2040));
      if (i == 3) mem_gnt = 1'b1;
      else tick();
    end
    tick();
    mem_gnt = 1'b0;
    chk("do_req_drop", 128'(mem_req), 128'(0));
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_0000_0001;
    nxt_ready  = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    ex = ta;
    ex.mpte = 64'hDEAD_BEEF_0000_0001;
    chk("do_uvalid", 128'(upd_valid), 128'(1));
    chk("do_udata", 128'(upd_data), 128'(ex));
    chk("do_nvalid", 128'(nxt_valid), 128'(1));
    chk("do_ndata", 128'(nxt_data), 128'(ex));
    tick();
    chk("do_upulse", 128'(upd_valid), 128'(0));
    chk("do_nhold", 128'(nxt_valid), 128'(1));
    nxt_ready = 1'b1;
    tick();
    chk("do_done", 128'(nxt_valid), 128'(0));

    // DO with bus error
    ta = mk(MPT_WALKING_DO, 32'h3000, 64'h1111);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    tick();
    fwd_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    chk("err_wait_uv", 128'(upd_valid), 128'(0));
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    nxt_ready  = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    ex = ta;
    ex.err = 1'b1;
    chk("err_uvalid", 128'(upd_valid), 128'(0));
    chk("err_nvalid", 128'(nxt_valid), 128'(1));
    chk("err_ndata", 128'(nxt_data), 128'(ex));
    nxt_ready = 1'b1;
    tick();
    chk("err_uvalid2", 128'(upd_valid), 128'(0));
    chk("err_done", 128'(nxt_valid), 128'(0));

    // back-to-back under backpressure
    ta = mk(MPT_WALKING_DO, 32'h4000, 64'h0);
    tb = mk(MPT_WALKING_DO, 32'h4100, 64'h0);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    nxt_ready = 1'b0;
    tick();
    fwd_data = tb;
    chk("b2b_rdy_req", 128'(fwd_ready), 128'(0));
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("b2b_rdy_wait", 128'(fwd_ready), 128'(0));
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hA;
    tick();
    mem_rvalid = 1'b0;
    ex = ta;
    ex.mpte = 64'hA;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_rdy", 128'(fwd_ready), 128'(0));
      chk("b2b_nvalid", 128'(nxt_valid), 128'(1));
      chk("b2b_ndata", 128'(nxt_data), 128'(ex));
      tick();
    end
    nxt_ready = 1'b1;
    chk("b2b_hs_nv", 128'(nxt_valid), 128'(1));
    tick();
    chk("b2b_idle_nv", 128'(nxt_valid), 128'(0));
    chk("b2b_idle_rdy", 128'(fwd_ready), 128'(1));
    tick();
    fwd_valid = 1'b0;
    chk("b2b_addr2", 128'(mem_addr), 128'(64'h4100));
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hB;
    tick();
    mem_rvalid = 1'b0;
    ex = tb;
    ex.mpte = 64'hB;
    chk("b2b_ndata2", 128'(nxt_data), 128'(ex));
    tick();
    chk("b2b_done2", 128'(nxt_valid), 128'(0));

    // flush while waiting for response
    ta = mk(MPT_WALKING_DO, 32'h5000, 64'h0);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    tick();
    fwd_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush   = MPT_FLUSH_ALL;
    chk("fl_rdy", 128'(fwd_ready), 128'(0));
    tick();
    flush = MPT_FLUSH_NONE;
    chk("fl_pend1", 128'(fstat), 128'(MPT_FLUSH_PENDING));
    chk("fl_nvalid", 128'(nxt_valid), 128'(0));
    tick();
    chk("fl_pend2", 128'(fstat), 128'(MPT_FLUSH_PENDING));
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hC;
    tick();
    mem_rvalid = 1'b0;
    chk("fl_done", 128'(fstat), 128'(MPT_FLUSH_DONE));
    chk("fl_uvalid", 128'(upd_valid), 128'(0));
    chk("fl_nvalid2", 128'(nxt_valid), 128'(0));
    chk("fl_rdy2", 128'(fwd_ready), 128'(1));
    tick();
    chk("fl_idle", 128'(fstat), 128'(MPT_FLUSH_IDLE));
    chk("fl_nvalid3", 128'(nxt_valid), 128'(0));

    // reset during REQ, then stray response
    ta = mk(MPT_WALKING_DO, 32'h6000, 64'h0);
    fwd_valid = 1'b1;
    fwd_data  = ta;
    tick();
    fwd_valid = 1'b0;
    chk("rr_req", 128'(mem_req), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_req0", 128'(mem_req), 128'(0));
    chk("rr_addr0", 128'(mem_addr), 128'(0));
    chk("rr_nvalid", 128'(nxt_valid), 128'(0));
    chk("rr_uvalid", 128'(upd_valid), 128'(0));
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hD;
    tick();
    mem_rvalid = 1'b0;
    chk("rr_stray_nv", 128'(nxt_valid), 128'(0));
    chk("rr_stray_uv", 128'(upd_valid), 128'(0));
    tick();
    chk("rr_stray_nv2", 128'(nxt_valid), 128'(0));
    chk("rr_stray_rdy", 128'(fwd_ready), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
